// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, register-bank write port,
// RUN/HALTED state machine and saturating retired-instruction counter.
module writeback_stage #(
  parameter int unsigned CNT_W  = 32,
  parameter logic [5:0]  HLT_OP = 6'b111111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_mem,
  input  logic             stall,
  input  logic             taken_branch,
  input  logic [31:0]      IR_mem,
  input  logic [31:0]      ALUout_mem,
  input  logic [31:0]      LMD_mem,
  output logic             wb_en,
  output logic [4:0]       rd_w,
  output logic [31:0]      LMD,
  output logic [31:0]      IR_wb,
  output logic             hlt,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state_q;
  logic [31:0]      ir_q;
  logic [31:0]      alu_q;
  logic [31:0]      lmd_q;
  logic             valid_q;
  logic             counted_q;
  logic [CNT_W-1:0] cnt_q;

  logic [5:0] opcode;
  logic       run;
  logic       capture;
  logic       count_en;
  logic       writes;
  logic       is_lw;
  logic [4:0] dest;

  assign opcode   = ir_q[31:26];
  assign run      = (state_q == RUN);
  assign capture  = run && !stall;
  // The held instruction retires once; the flag blocks recounting during stall.
  assign count_en = run && valid_q && !counted_q;

  // Classify the instruction in MEM/WB and pick its destination field.
  always_comb begin
    writes = 1'b0;
    is_lw  = 1'b0;
    dest   = '0;
    case (opcode)
      6'b000000, 6'b000001, 6'b000010,
      6'b000011, 6'b000100, 6'b000101: begin
        writes = 1'b1;
        dest   = ir_q[15:11];
      end
      6'b001010, 6'b001011, 6'b001100: begin
        writes = 1'b1;
        dest   = ir_q[20:16];
      end
      6'b001000: begin
        writes = 1'b1;
        is_lw  = 1'b1;
        dest   = ir_q[20:16];
      end
      default: begin
        writes = 1'b0;
      end
    endcase
  end

  // Pipeline register capture, retire counting and halt state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      ir_q      <= '0;
      alu_q     <= '0;
      lmd_q     <= '0;
      valid_q   <= 1'b0;
      counted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (capture) begin
        ir_q      <= IR_mem;
        alu_q     <= ALUout_mem;
        lmd_q     <= LMD_mem;
        valid_q   <= valid_mem && !taken_branch;
        counted_q <= 1'b0;
      end else if (count_en) begin
        counted_q <= 1'b1;
      end
      if (count_en && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (run && valid_q && (opcode == HLT_OP)) begin
        state_q <= HALTED;
      end
    end
  end

  assign wb_en   = valid_q && run && writes && (dest != 5'd0);
  assign rd_w    = wb_en ? dest : 5'd0;
  assign LMD     = wb_en ? (is_lw ? lmd_q : alu_q) : 32'd0;
  assign IR_wb   = ir_q;
  assign hlt     = (state_q == HALTED);
  assign retired = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver pushes predicted post-edge
// outputs, the monitor pops and compares one entry after each rising edge.
module tb_writeback_stage;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_mem, stall, taken_branch;
  logic [31:0]      IR_mem, ALUout_mem, LMD_mem;
  logic             wb_en;
  logic [4:0]       rd_w;
  logic [31:0]      LMD, IR_wb;
  logic             hlt;
  logic [CNT_W-1:0] retired;

  writeback_stage #(.CNT_W(CNT_W), .HLT_OP(6'b111111)) dut (
    .clk(clk), .rst(rst), .valid_mem(valid_mem), .stall(stall),
    .taken_branch(taken_branch), .IR_mem(IR_mem), .ALUout_mem(ALUout_mem),
    .LMD_mem(LMD_mem), .wb_en(wb_en), .rd_w(rd_w), .LMD(LMD), .IR_wb(IR_wb),
    .hlt(hlt), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] lmd;
    logic [31:0] ir;
    logic        h;
    int unsigned ret;
    int          id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int seq    = 0;

  // Reference model: what sits in WB, whether it has been counted, halt, count.
  logic [31:0] m_ir, m_alu, m_lmd;
  bit          m_valid, m_counted, m_halted;
  int unsigned m_cnt;

  function automatic void decode(input logic [31:0] ir, output bit wr,
                                 output bit lw, output logic [4:0] d);
    logic [5:0] op;
    op = ir[31:26];
    wr = 0; lw = 0; d = 5'd0;
    if (op <= 6'd5) begin
      wr = 1; d = ir[15:11];
    end else if (op == 6'b001010 || op == 6'b001011 || op == 6'b001100) begin
      wr = 1; d = ir[20:16];
    end else if (op == 6'b001000) begin
      wr = 1; lw = 1; d = ir[20:16];
    end
  endfunction

  task automatic model_reset();
    m_ir = '0; m_alu = '0; m_lmd = '0;
    m_valid = 0; m_counted = 0; m_halted = 0; m_cnt = 0;
  endtask

  // Apply inputs now (at a falling edge) and predict the outputs after the next rising edge.
  task automatic drive(input bit v, input bit s, input bit tb_, input logic [31:0] ir,
                       input logic [31:0] alu, input logic [31:0] lmd);
    bit   go_halt, wr, lw;
    logic [4:0] d;
    exp_t e;
    valid_mem = v; stall = s; taken_branch = tb_;
    IR_mem = ir; ALUout_mem = alu; LMD_mem = lmd;
    go_halt = 0;
    if (!m_halted) begin
      if (m_valid && !m_counted) begin
        if (m_cnt < MAXC) m_cnt++;
        m_counted = 1;
      end
      if (m_valid && m_ir[31:26] == 6'b111111) go_halt = 1;
      if (!s) begin
        m_ir = ir; m_alu = alu; m_lmd = lmd;
        m_valid = v && !tb_;
        m_counted = 0;
      end
    end
    if (go_halt) m_halted = 1;
    decode(m_ir, wr, lw, d);
    e.wb  = m_valid && !m_halted && wr && (d != 5'd0);
    e.rd  = e.wb ? d : 5'd0;
    e.lmd = e.wb ? (lw ? m_lmd : m_alu) : 32'd0;
    e.ir  = m_ir;
    e.h   = m_halted;
    e.ret = m_cnt;
    e.id  = seq++;
    q.push_back(e);
  endtask

  task automatic step(input bit v, input bit s, input bit tb_, input logic [31:0] ir,
                      input logic [31:0] alu, input logic [31:0] lmd);
    drive(v, s, tb_, ir, alu, lmd);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({wb_en, rd_w, LMD, IR_wb, hlt, retired} != '0) begin
      errors++;
      $display("FAIL %s: got wb=%0b rd=%0d lmd=%h ir=%h hlt=%0b ret=%0d, required all zero",
               name, wb_en, rd_w, LMD, IR_wb, hlt, retired);
    end
  endtask

  // Assert reset at a falling edge, check outputs clear immediately, release at the next one.
  task automatic do_reset();
    rst = 1;
    valid_mem = 0; stall = 0; taken_branch = 0;
    IR_mem = '0; ALUout_mem = '0; LMD_mem = '0;
    #1 check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_held");
    rst = 0;
    model_reset();
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (wb_en !== e.wb || rd_w !== e.rd || LMD !== e.lmd || IR_wb !== e.ir ||
          hlt !== e.h || retired !== CNT_W'(e.ret)) begin
        errors++;
        $display("FAIL wbout#%0d: got wb=%0b rd=%0d lmd=%h ir=%h hlt=%0b ret=%0d; exp wb=%0b rd=%0d lmd=%h ir=%h hlt=%0b ret=%0d",
                 e.id, wb_en, rd_w, LMD, IR_wb, hlt, retired,
                 e.wb, e.rd, e.lmd, e.ir, e.h, e.ret);
      end
    end
  end

  localparam logic [31:0] ADD_R5 = 32'h00432800;
  localparam logic [31:0] HLT    = 32'hFFFFFFFF;

  logic [5:0] ops [15];
  initial begin
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'b001010, 6'b001011,
            6'b001100, 6'b001000, 6'b001001, 6'b001101, 6'b001110,
            6'b010111, 6'b111110};
  end

  initial begin
    logic [31:0] ir;
    rst = 1;
    valid_mem = 0; stall = 0; taken_branch = 0;
    IR_mem = '0; ALUout_mem = '0; LMD_mem = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 5; i++) idle();

    // ADD R5, LW R18, ADDI to R0, SW.
    step(1, 0, 0, ADD_R5, 32'h11, 32'hDEAD_BEEF);
    idle();
    step(1, 0, 0, 32'h20120004, 32'h4, 32'h12345678);
    idle();
    step(1, 0, 0, 32'h28000005, 32'h5, 32'h0);
    step(1, 0, 0, 32'h24120004, 32'h4, 32'h0);
    idle();

    // Squashed HLT: no halt, no count.
    step(1, 0, 1, HLT, 32'h0, 32'h0);
    idle();
    idle();

    // Stall holding ADD R5 (taken_branch ignored while stalled), then reset mid-stall.
    step(1, 0, 0, ADD_R5, 32'h11, 32'h0);
    step(1, 1, 1, 32'h20120004, 32'h99, 32'h77);
    step(0, 1, 0, 32'h0, 32'h0, 32'h0);
    step(1, 1, 0, ADD_R5, 32'h22, 32'h0);
    drive(1, 1, 0, ADD_R5, 32'h22, 32'h0);
    #8 rst = 1;
    #1 check_zero("reset_mid_stall");
    @(negedge clk);
    rst = 0;
    model_reset();

    // HLT then ADD: halts, ADD never written, count frozen.
    step(1, 0, 0, HLT, 32'h0, 32'h0);
    step(1, 0, 0, ADD_R5, 32'h11, 32'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, ADD_R5, 32'h33, 32'h0);
    do_reset();

    // Halt entry coincides with stall: halt still occurs.
    step(1, 0, 0, HLT, 32'h0, 32'h0);
    step(1, 1, 0, ADD_R5, 32'h11, 32'h0);
    idle();
    do_reset();

    // Saturation: retire more than 2**CNT_W instructions.
    for (int i = 0; i < 20; i++) step(1, 0, 0, ADD_R5, i, 32'h0);
    idle();
    do_reset();

    // Randomized episodes.
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < 60; i++) begin
        ir = $urandom;
        if ($urandom_range(0, 39) == 0) ir[31:26] = 6'b111111;
        else ir[31:26] = ops[$urandom_range(0, 14)];
        step($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
             $urandom_range(0, 6) == 0, ir, $urandom, $urandom);
      end
      do_reset();
    end

    idle();
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (WB) stage of the 5-stage MIPS32 pipeline; the write side of the register bank that the decode stage reads.
- Registers the MEM/WB pipeline contents and classifies the retiring instruction.
- Drives the register-bank write port: enable, destination index and data.
- Owns the halt state machine and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter (saturating)
HLT_OP, 6'b111111, opcode that halts the pipeline

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_mem  in  1  MEM stage holds a real instruction
stall  in  1  hold the MEM/WB register; no new capture
taken_branch  in  1  instruction in MEM is on a squashed path; capture it as a bubble
IR_mem  in  32  instruction word from MEM
ALUout_mem  in  32  ALU result from MEM
LMD_mem  in  32  load data from MEM
wb_en  out  1  register-bank write strobe
rd_w  out  5  register-bank write index
LMD  out  32  register-bank write data
IR_wb  out  32  registered instruction, for debug/trace
hlt  out  1  pipeline halted (sticky)
retired  out  CNT_W  count of retired non-bubble instructions

Behaviour:
- Opcode field: IR[31:26].
- RR ALU class: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101. Destination is IR[15:11].
- RM ALU class: ADDI 001010, SUBI 001011, SLTI 001100. Destination is IR[20:16].
- LW 001000: destination is IR[20:16]; data comes from LMD_mem.
- SW 001001, BNEQZ 001101, BEQZ 001110 and any other opcode write nothing.
- Capture, on each rising clk: if not stall and state is RUN, capture IR_mem, ALUout_mem and LMD_mem into the MEM/WB register.
  - The captured valid bit is valid_mem && !taken_branch.
  - If stall is asserted, hold all contents.
- Outputs are combinational from the MEM/WB register, giving one cycle of latency from MEM inputs to the write.
  - A register written in WB is visible to decode from the next cycle; there is no internal bypass.
- wb_en = valid && state==RUN && class in {RR, RM, LW} && destination != 0.
  - R0 is never written, even when an instruction names it.
- rd_w = decoded destination. When wb_en=0, rd_w is 0 and LMD is 0, never stale values.
- LMD = LMD_mem value for LW, else the ALUout value.
- State machine has two states, RUN and HALTED:
  - RUN -> HALTED at the clock edge after a valid HLT_OP instruction occupies MEM/WB.
  - HALTED is sticky; only rst leaves it.
  - hlt = 1 in HALTED.
  - In HALTED: no capture, wb_en forced 0, retired frozen.
  - The HLT instruction itself writes nothing and counts as retired.
- retired increments by 1 on each edge where the MEM/WB register holds a valid instruction and the state is RUN.
  - It increments even during stall, but only once per held instruction: a retired flag is set on count and cleared on a new capture.
  - It saturates at all-ones and does not wrap.
- Bubble (valid=0) or squashed instruction: no write, no count, no halt, even if its IR is HLT_OP.
- Simultaneous events:
  - stall with taken_branch: stall wins, the register is held, and taken_branch is ignored that cycle.
  - Halt entry with stall: the halt still occurs.
- Reset (async, active-high, effective immediately, including mid-operation):
  - Register IR=0, valid=0, retired flag=0; state RUN.
  - All outputs are 0: wb_en=0, rd_w=0, LMD=0, IR_wb=0, hlt=0, retired=0.
  - Deasserting rst has effect only at the next rising edge.

Test Plan:
- Reset then idle (valid_mem=0) for 5 cycles -> wb_en=0, rd_w=0, LMD=0, hlt=0, retired=0 throughout.
- ADD R5 (IR_mem=32'h00432800, ALUout_mem=32'h0000_0011, valid_mem=1) -> next cycle: wb_en=1, rd_w=5, LMD=32'h11; retired=1 after the following edge.
- LW R18,4(R0) (IR_mem=32'h20120004, LMD_mem=32'h12345678, ALUout_mem=32'h4) -> wb_en=1, rd_w=18, LMD=32'h12345678.
- ADDI to R0 (IR_mem=32'h28000005), and separately SW (IR_mem=32'h24120004) -> wb_en=0 for both; retired increments by 2.
- HLT (IR_mem=32'hFFFFFFFF, valid) followed by ADD R5 -> hlt=1 from the edge after HLT enters WB; the ADD is never written; retired stays frozen. Separately, HLT with taken_branch=1 -> no halt, no count.
- Assert stall for 3 cycles holding ADD R5, then pulse rst mid-stall -> wb_en stays 1 with retired +1 only once before reset; on rst, all outputs go to 0 immediately, without waiting for clk.
